// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with valid/ready handshake, a DEPTH-entry skid FIFO
// behind the output register, bubble masking, flush and a saturating stall counter.
module pipe_skid_reg #(
    parameter int                 CTRL_W      = 8,
    parameter int                 DATA_W      = 128,
    parameter int                 DEPTH       = 2,
    parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = '0,
    parameter int                 CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int         PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    logic              out_valid_q, out_valid_d;
    logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [2:0]        skid_cnt_q, skid_cnt_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic [CTRL_W-1:0] skid_ctrl_mem [DEPTH];
    logic [DATA_W-1:0] skid_data_mem [DEPTH];

    logic accept;
    logic drain;
    logic push;

    // Explicit compare-and-clear so non-power-of-two depths wrap correctly.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign in_ready = (skid_cnt_q < DEPTH_C);
    assign accept   = in_valid & in_ready;
    assign drain    = out_valid_q & out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_ctrl_d  = out_ctrl_q;
        out_data_d  = out_data_q;
        skid_cnt_d  = skid_cnt_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        push        = 1'b0;

        if (flush) begin
            out_valid_d = 1'b0;
            skid_cnt_d  = '0;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
        end else if (drain && (skid_cnt_q != 3'd0)) begin
            out_ctrl_d = skid_ctrl_mem[rd_ptr_q];
            out_data_d = skid_data_mem[rd_ptr_q];
            rd_ptr_d   = next_ptr(rd_ptr_q);
            if (accept) begin
                push = 1'b1;
            end else begin
                skid_cnt_d = skid_cnt_q - 3'd1;
            end
        end else if (drain || !out_valid_q) begin
            out_valid_d = accept;
            if (accept) begin
                out_ctrl_d = in_ctrl;
                out_data_d = in_data;
            end
        end else if (accept) begin
            push       = 1'b1;
            skid_cnt_d = skid_cnt_q + 3'd1;
        end

        if (push) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end

        // Counts stall cycles even while flushing; only rst clears it.
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && !out_ready) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            skid_cnt_q  <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            skid_cnt_q  <= skid_cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Payload storage needs no reset: out_valid masks it on the outputs.
    always_ff @(posedge clk) begin
        out_ctrl_q <= out_ctrl_d;
        out_data_q <= out_data_d;
        if (push && !rst) begin
            skid_ctrl_mem[wr_ptr_q] <= in_ctrl;
            skid_data_mem[wr_ptr_q] <= in_data;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ctrl  = out_valid_q ? out_ctrl_q : BUBBLE_CTRL;
    assign out_data  = out_valid_q ? out_data_q : '0;
    assign occupancy = {2'b00, out_valid_q} + skid_cnt_q;
    assign stall_cnt = stall_cnt_q;

endmodule
